// File: rtl/cordic_phase_gen.sv
// Angle-stream NCO feeding a rotation-mode CORDIC core: emits z = phase_init + k*phase_inc
// over a valid/ready handshake with fixed x/y, for a counted run or until stopped.
module cordic_phase_gen #(
    parameter int XY_W    = 16,
    parameter int ANGLE_W = 32,
    parameter int CNT_W   = 16,
    parameter int X_INIT  = 19898
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic        [ANGLE_W-1:0] phase_init,
    input  logic        [ANGLE_W-1:0] phase_inc,
    input  logic        [CNT_W-1:0]   num_samples,
    output logic                      in_valid,
    input  logic                      in_ready,
    output logic signed [XY_W-1:0]    x_in,
    output logic signed [XY_W-1:0]    y_in,
    output logic signed [ANGLE_W-1:0] z_in,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [XY_W-1:0] X_INIT_V = XY_W'(X_INIT);

    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 stop_pend_q, stop_pend_d;
    logic                 cont_q, cont_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [ANGLE_W-1:0]   inc_q, inc_d;
    logic [ANGLE_W-1:0]   z_q, z_d;
    logic [XY_W-1:0]      x_q, x_d;
    logic [XY_W-1:0]      y_q, y_d;
    logic                 accept;
    logic                 last_beat;

    assign accept    = valid_q & in_ready;
    // A stop arriving on the same edge as an accepted beat makes that beat the last one.
    assign last_beat = (!cont_q && remaining_q == CNT_W'(1)) || stop_pend_q || stop;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        cont_d      = cont_q;
        remaining_d = remaining_q;
        inc_d       = inc_q;
        z_d         = z_q;
        x_d         = x_q;
        y_d         = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    inc_d       = phase_inc;
                    remaining_d = num_samples;
                    cont_d      = (num_samples == '0);
                    stop_pend_d = 1'b0;
                    z_d         = phase_init;
                    x_d         = X_INIT_V;
                    y_d         = '0;
                    valid_d     = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        valid_d     = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        z_d = z_q + inc_q;
                        if (!cont_q) begin
                            remaining_d = remaining_q - CNT_W'(1);
                        end
                    end
                end else if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            cont_q      <= 1'b0;
            remaining_q <= '0;
            inc_q       <= '0;
            z_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
            cont_q      <= cont_d;
            remaining_q <= remaining_d;
            inc_q       <= inc_d;
            z_q         <= z_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign in_valid = valid_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign z_in     = z_q;
    assign x_in     = x_q;
    assign y_in     = y_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Bench for cordic_phase_gen: vector table, randomized runs against an arithmetic
// model (beat k carries phase_init + k*phase_inc), plus hand sequences for stop/reset.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] phase_init = '0;
    logic [31:0] phase_inc = '0;
    logic [15:0] num_samples = '0;
    logic        in_valid;
    logic        in_ready = 1'b0;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [31:0] z_in;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    cordic_phase_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .phase_init(phase_init), .phase_inc(phase_inc), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: beats of a run are phase_init + k*phase_inc (mod 2^32).
    function automatic logic [31:0] model_z(input logic [31:0] pi, input logic [31:0] inc, input int k);
        return 32'(pi + 32'(k) * inc);
    endfunction

    // Reference: number of beats; stop_beat is the beat index (1-based) on whose acceptance stop is raised.
    function automatic int model_count(input logic [15:0] n, input int stop_beat);
        if (n == 0) return stop_beat;
        if (stop_beat > 0 && stop_beat < int'(n)) return stop_beat;
        return int'(n);
    endfunction

    // Drives one run from IDLE. All driving and sampling happens at the falling edge.
    task automatic run(input logic [31:0] pi, input logic [31:0] inc, input logic [15:0] n,
                       input int stop_beat, input int ready_pct, input bit noise,
                       output int cnt, output logic [31:0] last_z);
        bit finished;
        @(negedge clk);
        start = 1'b1; phase_init = pi; phase_inc = inc; num_samples = n;
        stop = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; last_z = '0; finished = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (in_valid) begin
                chk("beat_z", z_in, model_z(pi, inc, cnt));
                chk("beat_x", x_in, 16'd19898);
                chk("beat_y", y_in, 16'd0);
                chk("beat_busy_done", {busy, done}, 2'b10);
                in_ready = ($urandom_range(99) < ready_pct);
                stop = in_ready && (cnt + 1 == stop_beat);
                start = noise;
                if (noise) begin
                    phase_init = $urandom; phase_inc = $urandom; num_samples = 16'($urandom_range(9));
                end
                if (in_ready) begin
                    cnt++;
                    last_z = z_in;
                end
                @(negedge clk);
            end else begin
                start = 1'b0; stop = 1'b0; in_ready = 1'b0;
                chk("end_done_busy", {done, busy}, 2'b10);
                chk("end_z_hold", z_in, last_z);
                finished = 1'b1;
            end
        end
        if (!finished) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout: got no end of run, expected end within 600 cycles");
        end
        start = 1'b0; stop = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    typedef struct {
        logic [31:0] pi;
        logic [31:0] inc;
        logic [15:0] n;
        int          stop_beat;
        int          ready_pct;
        int          exp_cnt;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cnt;
        logic [31:0] last_z;

        vecs[0] = '{32'h0000_0000, 32'h4000_0000, 16'd4, 0, 100, 4, 32'hC000_0000};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 16'd2, 0, 100, 2, 32'h8000_0000};
        vecs[2] = '{32'h0000_0000, 32'h1000_0000, 16'd0, 3, 100, 3, 32'h2000_0000};
        vecs[3] = '{32'h1234_5678, 32'hF000_0000, 16'd5, 2, 60,  2, 32'h0234_5678};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 16'd3, 0, 50,  3, 32'h8000_0000};
        vecs[5] = '{32'h0000_0005, 32'hFFFF_FFFF, 16'd1, 0, 30,  1, 32'h0000_0005};

        // Reset values while held in reset
        #12;
        chk("reset_outputs", {in_valid, busy, done, x_in, y_in, z_in}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].pi, vecs[i].inc, vecs[i].n, vecs[i].stop_beat, vecs[i].ready_pct, 1'b1, cnt, last_z);
            $display("vec %0d: beats %0d last_z %08h", i, cnt, last_z);
            chk("vec_count", 64'(cnt), 64'(vecs[i].exp_cnt));
            chk("vec_last_z", last_z, vecs[i].exp_last);
        end

        // Backpressure held for 3 cycles on the second beat
        @(negedge clk);
        start = 1'b1; phase_init = '0; phase_inc = 32'h4000_0000; num_samples = 16'd4; in_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bp_beat1", z_in, 32'h0000_0000);
        @(negedge clk);
        in_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold", {in_valid, z_in}, {1'b1, 32'h4000_0000});
            @(negedge clk);
        end
        in_ready = 1'b1;
        chk("bp_beat2", {in_valid, z_in}, {1'b1, 32'h4000_0000});
        @(negedge clk);
        chk("bp_beat3", z_in, 32'h8000_0000);
        @(negedge clk);
        chk("bp_beat4", z_in, 32'hC000_0000);
        @(negedge clk);
        in_ready = 1'b0;
        chk("bp_end", {in_valid, busy, done}, 3'b001);
        $display("seq backpressure: end z %08h", z_in);
        @(negedge clk);

        // Continuous run; stop raised while the third beat is stalled
        start = 1'b1; phase_init = '0; phase_inc = 32'h1000_0000; num_samples = 16'd0; in_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cs_beat1", z_in, 32'h0000_0000);
        @(negedge clk);
        chk("cs_beat2", z_in, 32'h1000_0000);
        @(negedge clk);
        in_ready = 1'b0; stop = 1'b1;
        chk("cs_beat3", {in_valid, z_in}, {1'b1, 32'h2000_0000});
        @(negedge clk);
        stop = 1'b0;
        chk("cs_pend_hold1", {in_valid, busy, z_in}, {2'b11, 32'h2000_0000});
        @(negedge clk);
        chk("cs_pend_hold2", {in_valid, busy, z_in}, {2'b11, 32'h2000_0000});
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
        chk("cs_end", {in_valid, busy, done, z_in}, {3'b001, 32'h2000_0000});
        @(negedge clk);
        chk("cs_done_clear", done, 1'b0);
        $display("seq stop-while-stalled: end z %08h", z_in);

        // Reset mid-run: immediate idle, no done, then a fresh run
        start = 1'b1; phase_init = 32'hAAAA_0000; phase_inc = 32'h1; num_samples = 16'd0; in_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset", {in_valid, busy, done, x_in, y_in, z_in}, '0);
        @(negedge clk);
        chk("midrun_no_done", done, 1'b0);
        in_ready = 1'b0;
        rst_n = 1'b1;
        run(32'h5555_5555, 32'h3, 16'd3, 0, 100, 1'b0, cnt, last_z);
        $display("seq after reset: beats %0d last_z %08h", cnt, last_z);
        chk("post_reset_count", 64'(cnt), 64'd3);
        chk("post_reset_last", last_z, 32'h5555_555B);

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            logic [31:0] pi, inc;
            logic [15:0] n;
            int sb, pct, ec;
            pi = $urandom; inc = $urandom;
            n = 16'($urandom_range(8));
            sb = (n == 0) ? int'($urandom_range(8, 1)) : int'($urandom_range(10));
            pct = int'($urandom_range(100, 30));
            ec = model_count(n, sb);
            run(pi, inc, n, sb, pct, r[0], cnt, last_z);
            $display("rand %0d: n %0d stop@%0d beats %0d last_z %08h", r, n, sb, cnt, last_z);
            chk("rand_count", 64'(cnt), 64'(ec));
            chk("rand_last_z", last_z, model_z(pi, inc, ec - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
